// File: rtl/starflux_pkg.sv
// -----------------------------------------------------------------------------
// starflux_pkg
// Shared definitions for the gun fire controller slice: FSM state encoding,
// bullet-slot count and widths, and a small slot-index decode helper.
// -----------------------------------------------------------------------------
package starflux_pkg;

  localparam int NUM_SLOTS = 4;  // bullet slots tracked by the controller
  localparam int SLOT_W    = 2;  // width of a slot index
  localparam int GAP_W     = 4;  // width of the fire-gap counter
  localparam int HEAT_W    = 4;  // width of the heat input

  // State codes are exported on the debug/HUD port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRE   = 2'd1,
    ST_GAP    = 2'd2,
    ST_LOCKED = 2'd3
  } fire_state_e;

  // One-hot mask for a slot index.
  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
    return NUM_SLOTS'(1) << idx;
  endfunction

endpackage : starflux_pkg

// File: rtl/free_slot_picker.sv
// -----------------------------------------------------------------------------
// free_slot_picker
// Combinational lowest-index free slot finder.
//   busy_i     : occupancy vector, bit i set means slot i is in use
//   index_o    : lowest index whose busy bit is clear (0 when none free)
//   any_free_o : at least one slot is free
// -----------------------------------------------------------------------------
module free_slot_picker
  import starflux_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] busy_i,
  output logic [SLOT_W-1:0]    index_o,
  output logic                 any_free_o
);

  // Scan from the top down so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    index_o    = '0;
    any_free_o = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        index_o    = SLOT_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule : free_slot_picker

// File: rtl/gun_fire_controller.sv
// -----------------------------------------------------------------------------
// gun_fire_controller
// Rate-limited, heat-limited gun: turns a held fire request into single-cycle
// bullet spawns, allocates one of four bullet slots per shot, enforces a
// tick-counted gap between shots and locks out while the gun is too hot.
//
// Ports
//   clock        : system clock, rising edge
//   reset        : synchronous, active-high
//   tick         : one-cycle pacing pulse, counts down the fire gap
//   shoot        : player fire request (level)
//   heat         : current gun heat
//   bullet_done  : per-slot retire pulses, bit i frees slot i
//   spawn        : one-cycle bullet launch pulse (high during FIRE)
//   spawn_slot   : slot given to the bullet, valid while spawn=1, else 0
//   slot_busy    : registered slot occupancy
//   overheated   : high while LOCKED
//   state        : current FSM state code
// -----------------------------------------------------------------------------
module gun_fire_controller
  import starflux_pkg::*;
#(
  parameter int unsigned FIRE_GAP    = 4,   // ticks between shots, 1..15
  parameter int unsigned HEAT_MAX    = 15,  // lock at or above this heat
  parameter int unsigned HEAT_RESUME = 8    // unlock at or below this heat
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 shoot,
  input  logic [HEAT_W-1:0]    heat,
  input  logic [NUM_SLOTS-1:0] bullet_done,
  output logic                 spawn,
  output logic [SLOT_W-1:0]    spawn_slot,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic                 overheated,
  output logic [1:0]           state
);

  localparam logic [GAP_W-1:0]  GAP_LOAD    = GAP_W'(FIRE_GAP);
  localparam logic [HEAT_W-1:0] HEAT_LOCK   = HEAT_W'(HEAT_MAX);
  localparam logic [HEAT_W-1:0] HEAT_UNLOCK = HEAT_W'(HEAT_RESUME);

  fire_state_e          state_q, state_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [NUM_SLOTS-1:0] slot_busy_q, slot_busy_d;

  logic [SLOT_W-1:0]    free_idx;
  logic                 any_free;
  logic                 too_hot;
  logic                 cool_enough;

  assign too_hot     = (heat >= HEAT_LOCK);
  assign cool_enough = (heat <= HEAT_UNLOCK);

  // Picks from the registered occupancy, so a slot retired at an edge only
  // becomes allocatable in the cycle after that edge.
  free_slot_picker u_picker (
    .busy_i     (slot_busy_q),
    .index_o    (free_idx),
    .any_free_o (any_free)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      slot_busy_q <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      slot_busy_q <= slot_busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // Heat lockout outranks a fire request.
        if (too_hot)                state_d = ST_LOCKED;
        else if (shoot && any_free) state_d = ST_FIRE;
      end
      ST_FIRE: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        // A count of 0 cannot normally be seen here; treating it like 1
        // keeps the FSM from parking in GAP forever.
        if (too_hot)                       state_d = ST_LOCKED;
        else if (tick && gap_cnt_q <= 4'd1) state_d = ST_IDLE;
      end
      ST_LOCKED: begin
        if (cool_enough) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Gap counter: loaded on leaving FIRE, counted down by ticks in GAP,
  // cleared when overheating abandons the gap. Ticks outside GAP are ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (state_q == ST_FIRE) begin
      gap_cnt_d = GAP_LOAD;
    end else if (state_q == ST_GAP) begin
      if (too_hot)                     gap_cnt_d = '0;
      else if (tick && gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot occupancy: retire first, then claim the slot chosen in FIRE. The
  // claimed slot was free before the edge, so a retire pulse on it is a no-op
  // and the claim always survives.
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_busy_d = slot_busy_q & ~bullet_done;
    if (state_q == ST_FIRE && any_free) begin
      slot_busy_d = slot_busy_d | slot_onehot(free_idx);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (Moore, decoded from the registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    spawn      = (state_q == ST_FIRE);
    spawn_slot = spawn ? free_idx : '0;
    overheated = (state_q == ST_LOCKED);
    state      = state_q;
    slot_busy  = slot_busy_q;
  end

endmodule : gun_fire_controller

// File: tb/tb_gun_fire_controller.sv
// -----------------------------------------------------------------------------
// tb_gun_fire_controller
// Directed bench for gun_fire_controller with default parameters
// (FIRE_GAP=4, HEAT_MAX=15, HEAT_RESUME=8). Each expected spawn slot is queued
// when the firing stimulus is driven; a monitor pops and compares it whenever
// the DUT raises spawn.
// -----------------------------------------------------------------------------
module tb_gun_fire_controller;

  localparam int FIRE_GAP = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       shoot;
  logic [3:0] heat;
  logic [3:0] bullet_done;
  logic       spawn;
  logic [1:0] spawn_slot;
  logic [3:0] slot_busy;
  logic       overheated;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  gun_fire_controller #(
    .FIRE_GAP    (FIRE_GAP),
    .HEAT_MAX    (15),
    .HEAT_RESUME (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .shoot       (shoot),
    .heat        (heat),
    .bullet_done (bullet_done),
    .spawn       (spawn),
    .spawn_slot  (spawn_slot),
    .slot_busy   (slot_busy),
    .overheated  (overheated),
    .state       (state)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  // Single shot from IDLE with a free slot, then wait out the full gap.
  task automatic fire_once(input logic [1:0] slot);
    shoot = 1'b1;
    exp_q.push_back(slot);
    step();
    check("fire_once_state_fire", 8'(state), 8'd1);
    shoot = 1'b0;
    step();
    check("fire_once_state_gap", 8'(state), 8'd2);
    tick_n(FIRE_GAP);
    check("fire_once_back_idle", 8'(state), 8'd0);
  endtask

  // Scoreboard side: every spawn pulse must match the oldest queued slot.
  always @(negedge clock) begin
    if (spawn === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_spawn: observed slot=%0d expected no spawn", spawn_slot);
      end else begin
        check("spawn_slot", 8'(spawn_slot), 8'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    tick        = 1'b0;
    shoot       = 1'b0;
    heat        = 4'd0;
    bullet_done = 4'd0;
    step();
    step();

    // Reset state.
    check("rst_state", 8'(state), 8'd0);
    check("rst_spawn", 8'(spawn), 8'd0);
    check("rst_spawn_slot", 8'(spawn_slot), 8'd0);
    check("rst_slot_busy", 8'(slot_busy), 8'h0);
    check("rst_overheated", 8'(overheated), 8'd0);
    reset = 1'b0;

    // Held shoot: spawn one cycle later in slot 0, next one only after 4 ticks.
    shoot = 1'b1;
    exp_q.push_back(2'd0);
    step();
    check("t1_fire_state", 8'(state), 8'd1);
    check("t1_fire_spawn", 8'(spawn), 8'd1);
    step();
    check("t1_gap_state", 8'(state), 8'd2);
    check("t1_busy_0001", 8'(slot_busy), 8'h1);
    check("t1_spawn_low", 8'(spawn), 8'd0);
    tick_n(3);
    check("t1_still_gap_3ticks", 8'(state), 8'd2);
    exp_q.push_back(2'd1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("t1_idle_after_4ticks", 8'(state), 8'd0);
    step();
    check("t1_second_fire", 8'(state), 8'd1);
    // A tick during FIRE must not shorten the following gap.
    shoot = 1'b0;
    tick  = 1'b1;
    step();
    tick  = 1'b0;
    check("t1_gap2_state", 8'(state), 8'd2);
    check("t1_busy_0011", 8'(slot_busy), 8'h3);
    tick_n(3);
    check("tick_in_fire_ignored", 8'(state), 8'd2);
    tick_n(1);
    check("t1_gap2_done", 8'(state), 8'd0);

    // Fill remaining slots, then shoot with all busy.
    fire_once(2'd2);
    fire_once(2'd3);
    check("full_busy_1111", 8'(slot_busy), 8'hF);
    shoot = 1'b1;
    step();
    step();
    check("full_stays_idle", 8'(state), 8'd0);
    bullet_done = 4'b0100;
    exp_q.push_back(2'd2);
    step();
    bullet_done = 4'b0000;
    check("done_frees_slot2", 8'(slot_busy), 8'hB);
    step();
    check("refire_state", 8'(state), 8'd1);
    shoot = 1'b0;
    step();
    check("refire_busy_1111", 8'(slot_busy), 8'hF);
    tick_n(FIRE_GAP);
    check("refire_idle", 8'(state), 8'd0);

    // Overheat during GAP, hysteresis on the way out.
    bullet_done = 4'b1111;
    step();
    bullet_done = 4'b0000;
    check("all_freed", 8'(slot_busy), 8'h0);
    shoot = 1'b1;
    exp_q.push_back(2'd0);
    step();
    shoot = 1'b0;
    step();
    check("heat_gap_state", 8'(state), 8'd2);
    heat = 4'd15;
    step();
    check("heat_locked_state", 8'(state), 8'd3);
    check("heat_overheated", 8'(overheated), 8'd1);
    heat  = 4'd9;
    shoot = 1'b1;
    step();
    step();
    check("heat9_still_locked", 8'(state), 8'd3);
    heat  = 4'd8;
    shoot = 1'b0;
    step();
    check("heat8_idle", 8'(state), 8'd0);
    check("heat8_overheated_low", 8'(overheated), 8'd0);

    // In IDLE, heat lock outranks shoot.
    heat  = 4'd15;
    shoot = 1'b1;
    step();
    check("idle_heat_priority", 8'(state), 8'd3);
    heat  = 4'd0;
    shoot = 1'b0;
    step();
    check("idle_after_cool", 8'(state), 8'd0);

    // Free slot 0 on the same edge FIRE claims slot 1; heat just below lock.
    shoot = 1'b1;
    heat  = 4'd14;
    exp_q.push_back(2'd1);
    step();
    check("heat14_fires", 8'(state), 8'd1);
    bullet_done = 4'b0001;
    shoot       = 1'b0;
    step();
    bullet_done = 4'b0000;
    heat        = 4'd0;
    check("free_and_alloc_0010", 8'(slot_busy), 8'h2);

    // Reset mid-gap (count 3), then a fresh full-length gap.
    tick_n(1);
    check("mid_gap_state", 8'(state), 8'd2);
    reset = 1'b1;
    step();
    check("rst2_state", 8'(state), 8'd0);
    check("rst2_spawn", 8'(spawn), 8'd0);
    check("rst2_spawn_slot", 8'(spawn_slot), 8'd0);
    check("rst2_slot_busy", 8'(slot_busy), 8'h0);
    check("rst2_overheated", 8'(overheated), 8'd0);
    reset = 1'b0;
    shoot = 1'b1;
    exp_q.push_back(2'd0);
    step();
    check("post_rst_fire", 8'(spawn), 8'd1);
    shoot = 1'b0;
    step();
    check("post_rst_busy", 8'(slot_busy), 8'h1);
    tick_n(3);
    check("post_rst_full_gap", 8'(state), 8'd2);
    tick_n(1);
    check("post_rst_gap_done", 8'(state), 8'd0);

    step();
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gun_fire_controller

// File: doc/gun_fire_controller.md
GUN_FIRE_CONTROLLER -- requirements
Module: gun_fire_controller

Interface
REQ-001 SHALL have parameter FIRE_GAP, default 4, meaning ticks enforced between shots (legal range 1..15).
REQ-002 SHALL have parameter HEAT_MAX, default 15, meaning heat value at or above which the gun locks.
REQ-003 SHALL have parameter HEAT_RESUME, default 8, meaning heat value at or below which a locked gun unlocks (HEAT_RESUME < HEAT_MAX).
REQ-004 SHALL have port clock  input  1  system clock (50 MHz); all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port tick  input  1  one-cycle enable pulse from the rate divider; paces the fire gap.
REQ-007 SHALL have port shoot  input  1  player fire request (level).
REQ-008 SHALL have port heat  input  4  current gun heat from the cooldown counter.
REQ-009 SHALL have port bullet_done  input  4  per-slot retire pulse; bit i frees bullet slot i.
REQ-010 SHALL have port spawn  output  1  one-cycle pulse that launches a bullet.
REQ-011 SHALL have port spawn_slot  output  2  slot index allocated to the bullet; valid while spawn=1.
REQ-012 SHALL have port slot_busy  output  4  registered occupancy vector of the four bullet slots.
REQ-013 SHALL have port overheated  output  1  high while in LOCKED.
REQ-014 SHALL have port state  output  2  current FSM state code, for debug/HUD.

Function
REQ-015 SHALL implement the FSM states IDLE=0, FIRE=1, GAP=2, LOCKED=3.
REQ-016 In IDLE: heat>=HEAT_MAX SHALL move to LOCKED, taking priority over shoot.
REQ-017 In IDLE: shoot=1, heat<HEAT_MAX and at least one free slot SHALL move to FIRE.
REQ-018 In IDLE: shoot=1 with all slots busy SHALL remain in IDLE with no spawn.
REQ-019 FIRE SHALL last exactly one cycle, with spawn=1 and spawn_slot set to the lowest-index free slot (taken from slot_busy before this edge).
REQ-020 At the FIRE exit edge, that slot's busy bit SHALL be set, the gap counter SHALL load FIRE_GAP, and the FSM SHALL move to GAP.
REQ-021 Latency: shoot sampled in IDLE at edge N SHALL produce spawn=1 during cycle N+1.
REQ-022 In GAP, each tick SHALL decrement the gap counter; a tick when the count is 1 SHALL move to IDLE, giving exactly FIRE_GAP ticks per gap.
REQ-023 A tick arriving during FIRE SHALL be ignored.
REQ-024 In GAP, heat>=HEAT_MAX SHALL move to LOCKED, abandoning the remaining gap.
REQ-025 In LOCKED: overheated=1 and no spawn; heat<=HEAT_RESUME SHALL return to IDLE on the next edge, regardless of shoot.
REQ-026 bullet_done[i] SHALL clear slot_busy[i] at the next edge in any state; a done pulse on an already-free slot SHALL be a no-op.
REQ-027 A slot freed and a slot allocated at the same edge SHALL both take effect; a slot freed at that edge SHALL NOT be allocated until the next cycle.
REQ-028 A shoot held continuously SHALL yield one spawn per FIRE_GAP ticks (plus the FIRE and IDLE cycles) until heat or slots block firing.
REQ-029 The gap counter SHALL be 4 bits wide and SHALL never wrap below 0.

Reset
REQ-030 On reset: state=IDLE, spawn=0, spawn_slot=0, slot_busy=0000, overheated=0, gap counter=0.
REQ-031 Reset SHALL override all other inputs at that edge, including mid-FIRE, mid-GAP and LOCKED.

Structure
REQ-032 State encodings, NUM_SLOTS=4 and the slot-index width SHALL reside in shared package starflux_pkg.
REQ-033 Lowest-free-slot selection SHALL be a sub-module free_slot_picker (4-bit busy in; 2-bit index and any_free out; combinational).

Verification
REQ-034 Reset, then shoot=1, heat=0, FIRE_GAP=4 -> spawn one cycle later with slot 0; next spawn (slot 1) only after 4 ticks.
REQ-035 slot_busy=1111, shoot=1 -> no spawn; bullet_done=0100 -> next spawn uses slot 2.
REQ-036 heat=15 during GAP -> LOCKED and overheated=1; heat stepped down to 9 keeps LOCKED; heat=8 -> IDLE on the next edge.
REQ-037 bullet_done=0001 on the same edge as a FIRE that allocates slot 1 -> slot_busy ends as 0010.
REQ-038 Reset asserted during GAP with count 3 -> all outputs at reset values; a fresh shoot fires with no residual gap.
